// File: rtl/fir_sequencer.sv
// fir_sequencer: control/address sequencer in front of the folded FIR MAC.
// Accepts samples on a valid/ready handshake, writes them into the MAC's two
// sample RAMs (migrating the oldest half-line sample), sweeps the symmetric
// tap pairs, and registers the MAC result as the filter output. Coefficient
// loads are passed straight through to the MAC coefficient RAM.
// Build option: define FIR_CLR_ON_RST_EN to zero both sample RAMs after reset.
module fir_sequencer #(
   parameter int SIZE        = 43,
   parameter int COEFF_SIZE  = 16,
   parameter int SAMPLE_SIZE = 16,
   localparam int AW         = (SIZE > 1) ? $clog2(SIZE) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   din_valid,
   output logic                   din_ready,
   input  logic [SAMPLE_SIZE-1:0] din,
   input  logic                   c_load_valid,
   input  logic                   c_load_first,
   input  logic [COEFF_SIZE-1:0]  c_load_data,
   output logic                   mac_en,
   output logic                   mac_we,
   output logic                   mac_c_we,
   output logic [AW-1:0]          mac_c_addr,
   output logic [COEFF_SIZE-1:0]  mac_c_in,
   output logic [AW-1:0]          mac_wr_addr_0,
   output logic [AW-1:0]          mac_wr_addr_1,
   output logic [AW-1:0]          mac_rd_addr_0,
   output logic [AW-1:0]          mac_rd_addr_1,
   output logic [SAMPLE_SIZE-1:0] mac_mem_in_0,
   output logic [SAMPLE_SIZE-1:0] mac_mem_in_1,
   input  logic [SAMPLE_SIZE-1:0] mac_mem_out_0,
   input  logic [SAMPLE_SIZE-1:0] mac_dout,
   output logic [SAMPLE_SIZE-1:0] dout,
   output logic                   dout_valid
);

   typedef enum logic [2:0] {
      S_IDLE, S_READ_OLD, S_WRITE, S_MAC, S_DRAIN, S_OUT, S_CLEAR
   } state_t;

   localparam logic [AW-1:0] LAST   = AW'(SIZE - 1);
   localparam logic [AW:0]   SIZE_W = (AW+1)'(SIZE);
   localparam logic [AW:0]   INC_W  = (AW+1)'(1);

`ifdef FIR_CLR_ON_RST_EN
   localparam state_t RST_STATE = S_CLEAR;
`else
   localparam state_t RST_STATE = S_IDLE;
`endif

   state_t                 state, state_nxt;
   logic [AW-1:0]          ptr;
   logic [AW-1:0]          cnt;
   logic [AW-1:0]          k;
   logic [SAMPLE_SIZE-1:0] din_q;

   // Reduce a value in [0, 2*SIZE) modulo SIZE with one compare/subtract.
   function automatic logic [AW-1:0] mod_size(input logic [AW:0] v);
      logic [AW:0] t;
      t = (v >= SIZE_W) ? (v - SIZE_W) : v;
      return t[AW-1:0];
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= RST_STATE;
      else     state <= state_nxt;
   end

   // Next state and MAC-side outputs; everything is held at 0 while rst is high.
   always_comb begin
      state_nxt     = state;
      din_ready     = 1'b0;
      mac_en        = 1'b0;
      mac_we        = 1'b0;
      mac_c_we      = 1'b0;
      mac_c_addr    = '0;
      mac_c_in      = '0;
      mac_wr_addr_0 = '0;
      mac_wr_addr_1 = '0;
      mac_rd_addr_0 = '0;
      mac_rd_addr_1 = '0;
      mac_mem_in_0  = '0;
      mac_mem_in_1  = '0;
      if (!rst) begin
         case (state)
            S_IDLE: begin
               din_ready = !c_load_valid;
               if (c_load_valid) begin
                  mac_c_we   = 1'b1;
                  mac_c_addr = c_load_first ? '0 : cnt;
                  mac_c_in   = c_load_data;
               end
               if (din_valid && !c_load_valid) state_nxt = S_READ_OLD;
            end
            S_READ_OLD: begin
               mac_en        = 1'b1;
               mac_rd_addr_0 = ptr;
               state_nxt     = S_WRITE;
            end
            S_WRITE: begin
               mac_en        = 1'b1;
               mac_we        = 1'b1;
               mac_wr_addr_0 = ptr;
               mac_wr_addr_1 = ptr;
               mac_mem_in_0  = din_q;
               mac_mem_in_1  = mac_mem_out_0;
               state_nxt     = S_MAC;
            end
            S_MAC: begin
               mac_en        = 1'b1;
               mac_rd_addr_0 = mod_size({1'b0, ptr} + SIZE_W - {1'b0, k});
               mac_rd_addr_1 = mod_size({1'b0, ptr} + {1'b0, k} + INC_W);
               mac_c_addr    = k;
               if (k == LAST) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
               mac_en    = 1'b1;
               state_nxt = S_OUT;
            end
            S_OUT: begin
               state_nxt = S_IDLE;
            end
            S_CLEAR: begin
               mac_en        = 1'b1;
               mac_we        = 1'b1;
               mac_wr_addr_0 = k;
               mac_wr_addr_1 = k;
               if (k == LAST) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Sample pointer, coefficient counter, tap index and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= LAST;
         cnt        <= '0;
         k          <= '0;
         din_q      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         dout_valid <= 1'b0;
         if (state == S_IDLE && c_load_valid)
            cnt <= mod_size({1'b0, mac_c_addr} + INC_W);
         if (state == S_IDLE && din_valid && din_ready) begin
            din_q <= din;
            ptr   <= mod_size({1'b0, ptr} + INC_W);
         end
         case (state)
            S_WRITE:        k <= '0;
            S_MAC, S_CLEAR: k <= (k == LAST) ? '0 : k + 1'b1;
            S_OUT: begin
               dout       <= mac_dout;
               dout_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/fir_sequencer.md
# fir_sequencer

Control and address sequencer sitting directly upstream of the MAC in the FIR lowpass filter. It accepts input samples over a valid/ready handshake and stores each one into the MAC's two folded sample RAMs, migrating the oldest half-line sample between them. It then sweeps the symmetric tap pairs and coefficient addresses through the MAC, and registers the MAC result as the filter output. It also serialises coefficient loads into the MAC's coefficient RAM.

## Interface
- SIZE, 43: tap pairs (coefficient RAM depth, depth of each sample RAM); AW = $clog2(SIZE)
- COEFF_SIZE, 16: coefficient width
- SAMPLE_SIZE, 16: sample width
- clk  in  1  clock, rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-high
- din_valid / din_ready  in / out  1 / 1  sample handshake
- din  in  SAMPLE_SIZE  input sample
- c_load_valid  in  1  one coefficient word present this cycle
- c_load_first  in  1  with c_load_valid: word is coefficient 0
- c_load_data  in  COEFF_SIZE  coefficient word
- mac_en, mac_we, mac_c_we  out  1 each  to MAC en, WE, c_WE
- mac_c_addr  out  AW  to MAC c_addr
- mac_c_in  out  COEFF_SIZE  to MAC c_in
- mac_wr_addr_0, mac_wr_addr_1, mac_rd_addr_0, mac_rd_addr_1  out  AW each  to MAC
- mac_mem_in_0, mac_mem_in_1  out  SAMPLE_SIZE each  to MAC mem_in_0/1
- mac_mem_out_0  in  SAMPLE_SIZE  from MAC mem_out_0 (migration path)
- mac_dout  in  SAMPLE_SIZE  from MAC dout
- dout  out  SAMPLE_SIZE  filtered sample, held until next result
- dout_valid  out  1  one-cycle pulse when dout updates

## Operation
- The MAC's sample and coefficient RAMs have synchronous reads: data is valid 1 cycle after the address. MAC acc clears on the edge after the edge on which WE was sampled high.
- ptr: newest-sample address. Incremented modulo SIZE on each accepted sample. Reset value SIZE-1, so the first sample lands at address 0.
- All address arithmetic is modulo SIZE using compare/subtract. SIZE need not be a power of two.
- din_ready = (state==IDLE) && !c_load_valid. A coefficient load wins over a sample in the same cycle.
- Coefficient load: accepted only in IDLE. The cycle is combinational: mac_c_we=1, mac_c_addr=cnt, mac_c_in=c_load_data. cnt is forced to 0 when c_load_first is set, then increments and wraps SIZE-1 -> 0.
- States:
  - IDLE: mac_en=0. On din_valid&&din_ready: latch din, ptr<=ptr+1, go to READ_OLD.
  - READ_OLD (1 cycle): mac_en=1, rd_addr_0=ptr. Go to WRITE.
  - WRITE (1 cycle): mac_en=1, mac_we=1, wr_addr_0=wr_addr_1=ptr, mem_in_0=latched din, mem_in_1=mac_mem_out_0. This moves the oldest half-line sample into RAM 1. Go to MAC with k=0.
  - MAC (SIZE cycles, k=0..SIZE-1): mac_en=1, rd_addr_0=(ptr-k) mod SIZE, rd_addr_1=(ptr+1+k) mod SIZE, c_addr=k. After k=SIZE-1, go to DRAIN.
  - DRAIN (1 cycle): mac_en=1, addresses don't-care. Go to OUT.
  - OUT (1 cycle): mac_en=0. dout<=mac_dout and dout_valid<=1 at the closing edge. Go to IDLE.
- When not driving them: mac_we=0, mac_c_we=0, all address/data outputs 0.
- Reset: all outputs 0, dout=0, dout_valid=0, ptr=SIZE-1, cnt=0. A reset mid-sequence aborts it: no dout_valid, and the partial sum is discarded.

## Timing
- Acceptance edge E0 → dout_valid high in the cycle after edge E0+SIZE+4. That is 47 cycles for SIZE=43.
- din_ready is low for SIZE+4 cycles after acceptance. The next sample can be accepted in the same cycle dout_valid is high. Maximum rate is 1 sample per SIZE+5 clocks.
- The acc_rst timing of the MAC clears acc at the end of MAC k=0. The product of tap k is accumulated at the end of cycle k+1.

## Configuration
- FIR_CLR_ON_RST_EN defined: after rst deasserts, a CLEAR state runs for SIZE cycles. Each cycle drives mac_en=1, mac_we=1, both write addresses = i (0..SIZE-1), both mem_in = 0, with din_ready=0. It then enters IDLE.
- FIR_CLR_ON_RST_EN undefined: IDLE directly after reset. Outputs are undefined until 2*SIZE samples have been pushed.

## Test plan
- Reset with FIR_CLR_ON_RST_EN, SIZE=43 → din_ready=0 for 43 cycles; write addresses 0..42 with data 0; then din_ready=1.
- Load 44 coefficients, c_load_first on word 0 only → mac_c_addr 0..42 then 0; mac_c_we pulses 44 times. din_valid held high throughout sees din_ready=0.
- First sample 0x1000 after reset → WRITE at addr 0. MAC k=0: rd_addr_0=0, rd_addr_1=1; k=42: rd_addr_0=1, rd_addr_1=0. dout_valid exactly 47 cycles after acceptance.
- Push samples 1..44 → 44th write at addr 0 with mem_in_0=44, mem_in_1=1.
- With real MAC, symmetric coefficients, impulse 0x4000 then zeros → dout sequence matches golden model over 86 outputs.
- rst asserted at MAC k=10 → no dout_valid; dout=0; ptr=42; next sample written at addr 0.
